// File: rtl/glb_tile_streamer_pkg.sv
// Shared definitions for the GLB tile streamer.
//   tile_state_t : sequencer state / phase encoding (also exported for debug)
//   GLB_ADDR_W   : GLB word-address width
//   GLB_DATA_W   : GLB / stream data width
//   next_phase() : first phase after `cur` whose word count is nonzero
package glb_tile_streamer_pkg;

    localparam int GLB_ADDR_W = 16;
    localparam int GLB_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_W  = 3'd1,
        LD_IF = 3'd2,
        LD_IP = 3'd3,
        ST_OP = 3'd4,
        FIN   = 3'd5
    } tile_state_t;

    // nz = {op, ip, if, w} nonzero flags. Phases run in enum order, so a
    // phase is a candidate only if it comes after the current one.
    function automatic tile_state_t next_phase(tile_state_t cur, logic [3:0] nz);
        tile_state_t nxt;
        nxt = FIN;
        if (cur < LD_W && nz[0])
            nxt = LD_W;
        else if (cur < LD_IF && nz[1])
            nxt = LD_IF;
        else if (cur < LD_IP && nz[2])
            nxt = LD_IP;
        else if (cur < ST_OP && nz[3])
            nxt = ST_OP;
        return nxt;
    endfunction

endpackage

// File: rtl/glb_rd_skid.sv
// Two-entry FIFO that absorbs the one-cycle SRAM read latency so the
// downstream stream can stall without losing words.
//   clk, reset : clock, synchronous active-high reset
//   flush      : synchronous clear (same effect as reset)
//   push       : write push_data into the tail
//   pop        : drop the head entry
//   head       : current head entry (meaningful only when count != 0)
//   count      : number of stored entries (0..2)
// The caller never pushes when full or pops when empty.
module glb_rd_skid
    import glb_tile_streamer_pkg::*;
#(
    parameter int DATA_W = GLB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] store [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = store[rd_ptr];

endmodule

// File: rtl/glb_tile_streamer.sv
// GLB-side tile sequencer around the convolution unit. One start pulse runs
// one tile: weight, ifmap and ipsum words are read from the GLB and streamed
// out on cu_data, then opsum words coming back are written into the GLB.
//   start / *_base / *_words : tile launch and per-phase configuration
//   busy, done               : tile status
//   glb_*                    : synchronous-read SRAM port (rdata 1 cycle later)
//   cu_data, valid_*, ready_*: load streams toward the conv unit
//   cu_opsum, valid_op, ready_op : opsum stream from the conv unit
//   dbg_state                : current sequencer state (tile_state_t encoding)
// Handshake: a word transfers in any cycle where valid and ready are both 1;
// once valid is raised, it and its data stay unchanged until that transfer.
module glb_tile_streamer
    import glb_tile_streamer_pkg::*;
#(
    parameter int ADDR_W = GLB_ADDR_W,
    parameter int DATA_W = GLB_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] if_base,
    input  logic [ADDR_W-1:0] ip_base,
    input  logic [ADDR_W-1:0] op_base,
    input  logic [CNT_W-1:0]  w_words,
    input  logic [CNT_W-1:0]  if_words,
    input  logic [CNT_W-1:0]  ip_words,
    input  logic [CNT_W-1:0]  op_words,
    output logic              busy,
    output logic              done,
    output logic              glb_en,
    output logic              glb_we,
    output logic [ADDR_W-1:0] glb_addr,
    output logic [DATA_W-1:0] glb_wdata,
    input  logic [DATA_W-1:0] glb_rdata,
    output logic [DATA_W-1:0] cu_data,
    output logic              valid_w,
    output logic              valid_if,
    output logic              valid_ip,
    input  logic              ready_w,
    input  logic              ready_if,
    input  logic              ready_ip,
    input  logic [DATA_W-1:0] cu_opsum,
    input  logic              valid_op,
    output logic              ready_op,
    output logic [2:0]        dbg_state
);

    tile_state_t       state;
    logic [ADDR_W-1:0] w_base_q, if_base_q, ip_base_q, op_base_q;
    logic [CNT_W-1:0]  w_words_q, if_words_q, ip_words_q, op_words_q;
    logic [CNT_W-1:0]  issued, accepted, written;
    logic              inflight;

    logic [ADDR_W-1:0] cur_base;
    logic [CNT_W-1:0]  cur_words;
    logic              cur_ready;
    logic              is_load, strm_valid, pop, rd_issue, wr_fire;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [3:0]        nz_in, nz_q;

    assign nz_in = {op_words != '0, ip_words != '0, if_words != '0, w_words != '0};
    assign nz_q  = {op_words_q != '0, ip_words_q != '0, if_words_q != '0, w_words_q != '0};

    always_comb begin
        cur_base  = '0;
        cur_words = '0;
        cur_ready = 1'b0;
        case (state)
            LD_W:    begin cur_base = w_base_q;  cur_words = w_words_q;  cur_ready = ready_w;  end
            LD_IF:   begin cur_base = if_base_q; cur_words = if_words_q; cur_ready = ready_if; end
            LD_IP:   begin cur_base = ip_base_q; cur_words = ip_words_q; cur_ready = ready_ip; end
            default: begin cur_base = '0;        cur_words = '0;         cur_ready = 1'b0;     end
        endcase
    end

    assign is_load    = (state == LD_W) || (state == LD_IF) || (state == LD_IP);
    assign strm_valid = is_load && (fifo_count != 2'd0);
    assign pop        = strm_valid && cur_ready;

    // Words buffered plus the read in flight, after this cycle's pop, must
    // leave a free FIFO slot for the word a new read returns next cycle.
    assign rd_issue = is_load && (issued < cur_words) &&
                      (({1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);

    assign ready_op = (state == ST_OP) && (written < op_words_q);
    assign wr_fire  = ready_op && valid_op;

    assign glb_en    = rd_issue || wr_fire;
    assign glb_we    = wr_fire;
    assign glb_addr  = wr_fire  ? op_base_q + ADDR_W'(written) :
                       rd_issue ? cur_base + ADDR_W'(issued) : '0;
    assign glb_wdata = wr_fire ? cu_opsum : '0;

    assign cu_data   = strm_valid ? fifo_head : '0;
    assign valid_w   = strm_valid && (state == LD_W);
    assign valid_if  = strm_valid && (state == LD_IF);
    assign valid_ip  = strm_valid && (state == LD_IP);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign dbg_state = state;

    glb_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (state == FIN),
        .push      (inflight),
        .push_data (glb_rdata),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            w_base_q   <= '0;
            if_base_q  <= '0;
            ip_base_q  <= '0;
            op_base_q  <= '0;
            w_words_q  <= '0;
            if_words_q <= '0;
            ip_words_q <= '0;
            op_words_q <= '0;
            issued     <= '0;
            accepted   <= '0;
            written    <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= rd_issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_base_q   <= w_base;
                        if_base_q  <= if_base;
                        ip_base_q  <= ip_base;
                        op_base_q  <= op_base;
                        w_words_q  <= w_words;
                        if_words_q <= if_words;
                        ip_words_q <= ip_words;
                        op_words_q <= op_words;
                        issued     <= '0;
                        accepted   <= '0;
                        written    <= '0;
                        state      <= next_phase(IDLE, nz_in);
                    end
                end
                LD_W, LD_IF, LD_IP: begin
                    // Every issued word has been accepted, so the FIFO and
                    // the read pipe are empty before the phase changes.
                    if (accepted == cur_words) begin
                        issued   <= '0;
                        accepted <= '0;
                        state    <= next_phase(state, nz_q);
                    end else begin
                        if (rd_issue)
                            issued <= issued + CNT_W'(1);
                        if (pop)
                            accepted <= accepted + CNT_W'(1);
                    end
                end
                ST_OP: begin
                    if (written == op_words_q) begin
                        written <= '0;
                        state   <= FIN;
                    end else if (wr_fire) begin
                        written <= written + CNT_W'(1);
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/glb_tile_streamer.md
Name: glb_tile_streamer

Overview:
- GLB-side sequencer directly upstream and downstream of the convolution unit.
- On each `start` pulse it runs one tile, in order:
  - reads weight, ifmap and ipsum words from the GLB SRAM;
  - streams them over the valid/ready handshakes into the conv unit's 32-bit `data_in`;
  - takes back the opsum words the unit emits and writes them into the GLB.
- Turns a synchronous-read SRAM into back-pressure-safe streams, one tile at a time.

Parameters:
- ADDR_W, 16, GLB word-address width.
- DATA_W, 32, GLB / stream data width.
- CNT_W, 8, width of the per-phase word counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle tile launch pulse; ignored while busy=1
- w_base, if_base, ip_base, op_base  in  ADDR_W each  GLB base address per phase
- w_words, if_words, ip_words, op_words  in  CNT_W each  words per phase; 0 skips that phase
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the tile completes
- glb_en  out  1  SRAM access enable
- glb_we  out  1  SRAM write enable
- glb_addr  out  ADDR_W  SRAM word address
- glb_wdata  out  DATA_W  SRAM write data
- glb_rdata  in  DATA_W  SRAM read data, valid exactly 1 cycle after a read
- cu_data  out  DATA_W  stream data to the conv unit
- valid_w, valid_if, valid_ip  out  1  per-phase stream valid
- ready_w, ready_if, ready_ip  in  1  per-phase stream ready
- cu_opsum  in  DATA_W  opsum word from the conv unit
- valid_op  in  1  opsum valid
- ready_op  out  1  opsum ready

Behaviour:
- Clocking: single clock `clk`; `reset` is synchronous, active-high.
- Reset values: all outputs 0; FSM = IDLE; FIFO empty; all counters 0; any in-flight read is discarded.
- Reset mid-tile: same as above. No done pulse is generated and nothing further is written.
- Configuration capture:
  - Base and count inputs are registered when start is accepted.
  - Later changes to those inputs have no effect until the next tile.
- FSM states: IDLE, LD_W, LD_IF, LD_IP, ST_OP, FIN.
  - IDLE: start moves to the first phase with a nonzero count, in the order LD_W, LD_IF, LD_IP, ST_OP. If all counts are 0, go directly to FIN.
  - A load phase ends once `accepted == words`; move to the next nonzero phase.
  - ST_OP ends once `written == op_words`.
  - FIN: done=1 for one cycle, then IDLE. busy=0 in IDLE.
- Read path (load phases):
  - Read-issue rule: issue a read when `issued < words` and `fifo_count + inflight - pop < 2`.
  - A read drives glb_en=1, glb_we=0, glb_addr = base + issued (modulo 2^ADDR_W).
  - glb_rdata is pushed into a 2-entry FIFO on the following cycle.
  - cu_data = FIFO head. Only the current phase's valid is asserted, and only while the FIFO is non-empty; the other valids stay 0.
  - Pop happens on valid & ready for the current phase.
  - Valid and data hold stable while ready=0.
  - No read is issued past `words`.
  - The phase changes only after the FIFO has drained, so words never cross phases.
- Latency: start accepted at cycle 0 → glb_en at cycle 1 → valid at cycle 3. With ready held high, throughput is 1 word/cycle.
- Write path (ST_OP):
  - ready_op = 1 while `written < op_words`.
  - On valid_op & ready_op, in the same cycle: glb_en=1, glb_we=1, glb_addr = op_base + written, glb_wdata = cu_opsum.
  - There is no write buffering. Reads and writes never overlap because phases are sequential.
- Boundaries:
  - words = 255 is a legal count.
  - A base address near 2^16 wraps around.
  - ready toggling every cycle loses and duplicates no words.
  - A start pulse while busy is ignored, including in the FIN cycle.

Decomposition:
- Shared package (e.g. `conv_pkg`):
  - phase/state enum `tile_state_t`;
  - constants `GLB_ADDR_W` and `GLB_DATA_W`.
- One natural sub-module, `glb_rd_skid`: the 2-entry FIFO with count output, push/pop and flush.

Test Plan:
- Basic stream: w_words=4, if_words=4, ip_words=8, op_words=8, all readys high, SRAM[w_base+i]=0xA000_0000+i → valid_w words 0xA000_0000..0xA000_0003 on consecutive cycles. Then IF, IP and 8 opsum writes at op_base..op_base+7. done pulses exactly once.
- Backpressure: ready_if = random 50% with if_words=32 → exactly 32 in-order ifmap words. At most 2 reads outstanding plus buffered at any time. Data stays stable while stalled.
- Phase skip: w_words=0, ip_words=0 → sequence goes IDLE→LD_IF→ST_OP. valid_w and valid_ip never assert.
- Address wrap: if_base=0xFFFE, if_words=4 → read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-tile: assert reset during LD_IP after 3 of 8 words → next cycle all outputs are 0. A fresh start replays the full tile correctly, with no stale FIFO data.
- Start while busy: a second start pulse during LD_W is ignored. Registered counts stay unchanged and a single done pulse occurs.
